intersection_ctrl: RTL and testbench
====================================

# intersection_ctrl

Parametrised N-approach traffic-light controller, successor to the two-approach North/East controller. It grants green to one approach at a time and serves waiting approaches in round-robin order. Every change of green passes through a yellow phase and an all-red clearance phase, and a single emergency preempt input can force a chosen approach to green. It sits between the debounced, synchronised vehicle-sensor bank and the lamp drivers, which take active-low lamp outputs.

## Interface
Parameters:
- N_DIR, 4: number of approaches (2..8).
- GREEN_T, 30: minimum green time; green lasts at least GREEN_T+1 cycles.
- YELLOW_T, 5: yellow lasts exactly YELLOW_T+1 cycles.
- ALLRED_T, 2: all-red clearance lasts exactly ALLRED_T+1 cycles.
- CNT_W, 5: counter width; must be ≥ clog2(max(GREEN_T,YELLOW_T,ALLRED_T)+1). Elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sensor  in  N_DIR  bit i set = vehicle waiting on approach i; already synchronous to clk.
- preempt  in  1  emergency request.
- preempt_dir  in  clog2(N_DIR)  approach to force green; values ≥ N_DIR are ignored (treated as no preempt).
- red_n / yellow_n / green_n  out  N_DIR each  active-low lamps, bit i = approach i.
- state  out  2  current phase.
- active  out  clog2(N_DIR)  approach currently owning green/yellow.
- counter  out  CNT_W  phase timer.

## Operation
- Phases: ST_ALLRED=0, ST_GREEN=1, ST_YELLOW=2. Encoding 3 is illegal and recovers to ST_ALLRED with counter=0 on the next edge.
- Reset asserted: state=ST_ALLRED, active=0, next=0, counter=0. All red_n=0, all yellow_n and green_n=1.
- Lamps (registered from state/active, combinational decode, no glitch on non-changing bits):
  - Exactly one lamp is low per approach at all times.
  - Approach `active` shows green in ST_GREEN and yellow in ST_YELLOW.
  - Every other case shows red.
- ST_ALLRED: counter counts 0..ALLRED_T. At ALLRED_T: active←next, counter←0, go to ST_GREEN.
- ST_GREEN: counter increments and saturates at GREEN_T. Each cycle, evaluate in priority order:
  - Preempt valid and preempt_dir≠active: next←preempt_dir, counter←0, go to ST_YELLOW, regardless of counter.
  - Preempt valid and preempt_dir==active: hold green, no switch.
  - counter==GREEN_T and some sensor[j] set with j≠active: next←round-robin pick, counter←0, go to ST_YELLOW.
  - Otherwise stay in ST_GREEN. Green holds indefinitely with no competing request.
- Round-robin pick: first j set in sensor, searching active+1, active+2, … mod N_DIR, excluding active. The sensor of the active approach is ignored.
- ST_YELLOW: counter 0..YELLOW_T, then counter←0, go to ST_ALLRED. Yellow is never aborted.
- Preempt arriving in ST_YELLOW or ST_ALLRED: next←preempt_dir, overriding any round-robin choice. Latest value wins up to the last ALLRED cycle.
- Preempt deasserted while its approach is green: normal rules resume. The counter has already saturated, so a competing request switches immediately.

## Timing
- Green entered at edge t (counter=0). The earliest yellow is at edge t+GREEN_T+1 if a request is present at counter==GREEN_T.
- Full handover (yellow + all-red) = YELLOW_T+ALLRED_T+2 cycles. The new green appears at edge t+GREEN_T+YELLOW_T+ALLRED_T+3.
- Preempt in ST_GREEN: yellow on the next edge (1-cycle latency).
- Outputs change only on clk edges, except on reset assertion, which forces outputs to the reset values immediately (asynchronous).

## Structure
- Package intersection_pkg holds:
  - state encoding constants ST_ALLRED/ST_GREEN/ST_YELLOW and the phase typedef;
  - a function returning the minimum CNT_W for given times.
- Sub-module rr_pick (parameter N_DIR): combinational; inputs req and last, outputs grant index and grant_valid. It is instantiated once.
- Top block: phase FSM, counter, active/next registers, lamp decode.

## Test plan
All scenarios use N_DIR=4, GREEN_T=30, YELLOW_T=5, ALLRED_T=2.
- Reset release, sensor=0 → ALLRED for 3 cycles, then approach 0 green. Green holds for 200 cycles with counter=30.
- sensor=4'b0110 from reset release → green order 0→1→2→1→2…. Each handover: 6 yellow cycles, 3 all-red cycles, green ≥31 cycles. Approach 3 never green.
- Approach 0 green at counter=10, sensor=4'b1000 → approach 0 yellow exactly at counter 30+1. Approach 3 green 9 cycles later.
- Approach 0 green at counter=3, preempt=1, preempt_dir=2 → yellow on the next edge, then approach 2 green. Green stays while preempt=1 even with sensor=4'b1011.
- Preempt with preempt_dir=1 raised during yellow, while round-robin had chosen 3 → approach 1 green after all-red.
- reset asserted mid-yellow → all red immediately, counter=0, active=0. Restart behaves as the first scenario.
- Lamp invariant checked every cycle: exactly one lamp low per approach.

Source files
------------

// File: rtl/intersection_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// intersection_pkg : phase encoding and counter-width helper
// Revision: 1.0
// ----------------------------------------------------------------------
package intersection_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t ST_ALLRED = 2'd0;
  localparam phase_t ST_GREEN  = 2'd1;
  localparam phase_t ST_YELLOW = 2'd2;

  // Smallest counter width able to reach the longest phase limit.
  function automatic int min_cnt_w(input int green_t, input int yellow_t, input int allred_t);
    int m;
    m = green_t;
    if (yellow_t > m) m = yellow_t;
    if (allred_t > m) m = allred_t;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------
// rr_pick : first requesting approach after 'last', 'last' excluded
// Revision: 1.0
// ----------------------------------------------------------------------
module rr_pick #(
  parameter int N_DIR = 4
) (
  input  logic [N_DIR-1:0]         req,
  input  logic [$clog2(N_DIR)-1:0] last,
  output logic [$clog2(N_DIR)-1:0] grant,
  output logic                     grant_valid
);

  localparam int AW = $clog2(N_DIR);

  logic [N_DIR-1:0] rot;
  int               sum;

  // rot[k] is the request of approach (last + k) mod N_DIR
  assign rot = N_DIR'({req, req} >> last);

  // Descending scan so the nearest requester overwrites farther ones.
  always_comb begin
    grant       = last;
    grant_valid = 1'b0;
    sum         = 0;
    for (int k = N_DIR - 1; k >= 0; k--) begin
      if ((k != 0) && rot[k]) begin
        sum = int'(last) + k;
        if (sum >= N_DIR) sum = sum - N_DIR;
        grant       = AW'(sum);
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// intersection_ctrl : N-approach round-robin traffic-light controller
// Revision: 1.0
// ----------------------------------------------------------------------
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int N_DIR    = 4,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DIR-1:0]         sensor,
  input  logic                     preempt,
  input  logic [$clog2(N_DIR)-1:0] preempt_dir,
  output logic [N_DIR-1:0]         red_n,
  output logic [N_DIR-1:0]         yellow_n,
  output logic [N_DIR-1:0]         green_n,
  output logic [1:0]               state,
  output logic [$clog2(N_DIR)-1:0] active,
  output logic [CNT_W-1:0]         counter
);

  localparam int AW = $clog2(N_DIR);
  localparam logic [CNT_W-1:0] GREEN_MAX  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_MAX = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_MAX = CNT_W'(ALLRED_T);

  if (CNT_W < min_cnt_w(GREEN_T, YELLOW_T, ALLRED_T)) begin : g_cnt_w_check
    $error("CNT_W too small for the configured phase times");
  end
  if (N_DIR < 2 || N_DIR > 8) begin : g_n_dir_check
    $error("N_DIR must be within 2..8");
  end

  logic [AW-1:0]    next_dir;
  logic [AW-1:0]    rr_grant;
  logic             rr_valid;
  logic             pre_valid;
  logic [N_DIR-1:0] sel;

  assign pre_valid = preempt && (32'(preempt_dir) < N_DIR);

  rr_pick #(.N_DIR(N_DIR)) u_rr_pick (
    .req         (sensor),
    .last        (active),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ALLRED;
      active   <= '0;
      next_dir <= '0;
      counter  <= '0;
    end else begin
      case (state)
        ST_ALLRED: begin
          if (pre_valid) next_dir <= preempt_dir;
          if (counter == ALLRED_MAX) begin
            // a preempt in the final clearance cycle still wins
            active  <= pre_valid ? preempt_dir : next_dir;
            counter <= '0;
            state   <= ST_GREEN;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        ST_GREEN: begin
          if (pre_valid && (preempt_dir != active)) begin
            next_dir <= preempt_dir;
            counter  <= '0;
            state    <= ST_YELLOW;
          end else if (!pre_valid && (counter == GREEN_MAX) && rr_valid) begin
            next_dir <= rr_grant;
            counter  <= '0;
            state    <= ST_YELLOW;
          end else if (counter != GREEN_MAX) begin
            counter <= counter + CNT_W'(1);
          end
        end
        ST_YELLOW: begin
          if (pre_valid) next_dir <= preempt_dir;
          if (counter == YELLOW_MAX) begin
            counter <= '0;
            state   <= ST_ALLRED;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          counter <= '0;
          state   <= ST_ALLRED;
        end
      endcase
    end
  end

  // Lamps decode straight from registered phase/owner; red is lit whenever neither other lamp is.
  assign sel      = N_DIR'(1) << active;
  assign green_n  = (state == ST_GREEN)  ? ~sel : '1;
  assign yellow_n = (state == ST_YELLOW) ? ~sel : '1;
  assign red_n    = ~(green_n & yellow_n);

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_intersection_ctrl : directed scenarios checked against a phase model
// Revision: 1.0
// ----------------------------------------------------------------------
module tb_intersection_ctrl;

  localparam int N  = 4;
  localparam int GT = 30;
  localparam int YT = 5;
  localparam int AT = 2;
  localparam int CW = 5;

  logic       clk;
  logic       reset;
  logic       preempt;
  logic [3:0] sensor;
  logic [1:0] preempt_dir;
  logic [3:0] red_n, yellow_n, green_n;
  logic [1:0] state;
  logic [1:0] active;
  logic [4:0] counter;

  int total = 0;
  int bad   = 0;

  intersection_ctrl #(
    .N_DIR(N), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor      (sensor),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .red_n       (red_n),
    .yellow_n    (yellow_n),
    .green_n     (green_n),
    .state       (state),
    .active      (active),
    .counter     (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model: phase, age in phase, owner, target
  int m_phase  = 0;
  int m_age    = 0;
  int m_owner  = 0;
  int m_target = 0;
  bit m_pv;
  int m_pick;

  function automatic int rr_model(input logic [3:0] req, input int owner);
    for (int d = 1; d < N; d++)
      if (req[(owner + d) % N]) return (owner + d) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_age = 0; m_owner = 0; m_target = 0;
    end else begin
      m_pv   = preempt && (int'(preempt_dir) < N);
      m_pick = rr_model(sensor, m_owner);
      if (m_phase == 0) begin
        if (m_pv) m_target = int'(preempt_dir);
        if (m_age >= AT) begin m_owner = m_target; m_phase = 1; m_age = 0; end
        else m_age++;
      end else if (m_phase == 1) begin
        if (m_pv && int'(preempt_dir) != m_owner) begin
          m_target = int'(preempt_dir); m_phase = 2; m_age = 0;
        end else if (!m_pv && m_age >= GT && m_pick >= 0) begin
          m_target = m_pick; m_phase = 2; m_age = 0;
        end else m_age++;
      end else begin
        if (m_pv) m_target = int'(preempt_dir);
        if (m_age >= YT) begin m_phase = 0; m_age = 0; end
        else m_age++;
      end
    end
  end

  // ---------------- per-cycle compare and phase-run monitor
  int         c_lim, c_cnt, zeros, prev_state, run;
  logic [3:0] e_r, e_y, e_g;
  bit         rec_en = 1'b0;
  bit         dur_en = 1'b0;
  int         greens[$];

  always @(negedge clk) begin
    c_lim = (m_phase == 1) ? GT : (m_phase == 2) ? YT : AT;
    c_cnt = (m_age < c_lim) ? m_age : c_lim;
    for (int i = 0; i < N; i++) begin
      e_g[i] = !(m_phase == 1 && m_owner == i);
      e_y[i] = !(m_phase == 2 && m_owner == i);
      e_r[i] = (m_phase == 1 || m_phase == 2) && (m_owner == i);
    end
    chk("state", 32'(state), 32'(m_phase));
    chk("active", 32'(active), 32'(m_owner));
    chk("counter", 32'(counter), 32'(c_cnt));
    chk("red_n", 32'(red_n), 32'(e_r));
    chk("yellow_n", 32'(yellow_n), 32'(e_y));
    chk("green_n", 32'(green_n), 32'(e_g));
    for (int i = 0; i < N; i++) begin
      zeros = int'(!red_n[i]) + int'(!yellow_n[i]) + int'(!green_n[i]);
      chk("one_lamp_low", 32'(zeros), 32'd1);
    end
    if (!reset) begin
      run = 0;
      prev_state = int'(state);
    end else if (int'(state) != prev_state) begin
      if (dur_en && prev_state == 2) chk("yellow_len", 32'(run), 32'(YT + 1));
      if (dur_en && prev_state == 0) chk("allred_len", 32'(run), 32'(AT + 1));
      if (dur_en && prev_state == 1) chk("green_len_min", 32'(run >= GT + 1), 32'd1);
      if (rec_en && state == 2'd1) greens.push_back(int'(active));
      run = 1;
      prev_state = int'(state);
    end else begin
      run++;
    end
  end

  task automatic restart(input logic [3:0] s);
    reset   = 1'b0;
    preempt = 1'b0;
    sensor  = s;
    tick(2);
    reset = 1'b1;
  endtask

  // ---------------- directed scenarios
  int exp_order[5] = '{0, 1, 2, 1, 2};
  int seen3;

  initial begin
    reset = 1'b0; sensor = 4'b0; preempt = 1'b0; preempt_dir = 2'd0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_counter", 32'(counter), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_red_n", 32'(red_n), 32'h0);
    chk("rst_green_n", 32'(green_n), 32'hF);

    // idle start: three all-red cycles, then approach 0 holds green
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("s1_state", 32'(state), 32'd1);
    chk("s1_active", 32'(active), 32'd0);
    chk("s1_model_phase", 32'(m_phase), 32'd1);
    tick(200);
    chk("s1_hold_counter", 32'(counter), 32'd30);
    chk("s1_hold_state", 32'(state), 32'd1);

    // round-robin between approaches 1 and 2
    greens.delete();
    rec_en = 1'b1; dur_en = 1'b1;
    restart(4'b0110);
    tick(200);
    rec_en = 1'b0; dur_en = 1'b0;
    chk("s2_green_count", 32'(greens.size()), 32'd5);
    seen3 = 0;
    for (int i = 0; i < greens.size(); i++) begin
      if (i < 5) chk("s2_green_order", 32'(greens[i]), 32'(exp_order[i]));
      if (greens[i] == 3) seen3++;
    end
    chk("s2_no_green3", 32'(seen3), 32'd0);

    // late request: yellow exactly one cycle after counter reaches 30
    restart(4'b0000);
    tick(13);
    chk("s3_counter10", 32'(counter), 32'd10);
    sensor = 4'b1000;
    tick(20);
    chk("s3_still_green", 32'(state), 32'd1);
    chk("s3_counter30", 32'(counter), 32'd30);
    tick(1);
    chk("s3_yellow", 32'(state), 32'd2);
    chk("s3_yellow_cnt", 32'(counter), 32'd0);
    tick(9);
    chk("s3_green_state", 32'(state), 32'd1);
    chk("s3_green_dir", 32'(active), 32'd3);
    chk("s3_model_owner", 32'(m_owner), 32'd3);

    // preempt from green at counter 3, then hold against competing sensors
    restart(4'b0000);
    tick(6);
    chk("s4_counter3", 32'(counter), 32'd3);
    preempt = 1'b1; preempt_dir = 2'd2; sensor = 4'b1011;
    tick(1);
    chk("s4_yellow", 32'(state), 32'd2);
    chk("s4_yellow_dir", 32'(active), 32'd0);
    tick(9);
    chk("s4_green_state", 32'(state), 32'd1);
    chk("s4_green_dir", 32'(active), 32'd2);
    tick(100);
    chk("s4_hold_state", 32'(state), 32'd1);
    chk("s4_hold_dir", 32'(active), 32'd2);
    chk("s4_hold_counter", 32'(counter), 32'd30);
    preempt = 1'b0;
    tick(1);
    chk("s4_release_yellow", 32'(state), 32'd2);
    tick(9);
    chk("s4_after_dir", 32'(active), 32'd3);

    // preempt during yellow overrides the round-robin choice of 3
    restart(4'b1000);
    tick(34);
    chk("s5_yellow", 32'(state), 32'd2);
    preempt = 1'b1; preempt_dir = 2'd1;
    tick(2);
    preempt = 1'b0;
    tick(7);
    chk("s5_green_state", 32'(state), 32'd1);
    chk("s5_green_dir", 32'(active), 32'd1);

    // asynchronous reset in the middle of yellow
    restart(4'b0010);
    tick(36);
    chk("s6_mid_yellow", 32'(state), 32'd2);
    chk("s6_mid_cnt", 32'(counter), 32'd2);
    #1 reset = 1'b0;
    #1;
    chk("s6_rst_state", 32'(state), 32'd0);
    chk("s6_rst_counter", 32'(counter), 32'd0);
    chk("s6_rst_active", 32'(active), 32'd0);
    chk("s6_rst_red_n", 32'(red_n), 32'h0);
    chk("s6_rst_yellow_n", 32'(yellow_n), 32'hF);
    chk("s6_rst_green_n", 32'(green_n), 32'hF);
    @(posedge clk);
    #1;
    sensor = 4'b0000;
    reset  = 1'b1;
    tick(3);
    chk("s6_restart_green", 32'(state), 32'd1);
    chk("s6_restart_dir", 32'(active), 32'd0);
    tick(40);
    chk("s6_restart_hold", 32'(counter), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
